// File: rtl/rf_scoreboard.sv
// Integer register file with per-register busy scoreboard and optional
// same-cycle writeback forwarding onto the two combinational read ports.
module rf_scoreboard #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [AW-1:0]   rd_reg1,
    input  logic [AW-1:0]   rd_reg2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    input  logic            RegWrite,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_reg,
    output logic [AW:0]     busy_count
);

    logic [XLEN-1:0] mem_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     busy_count_reg;
    logic [AW:0]     busy_count_next;

    logic wr_en;
    logic iss_en;

    assign wr_en  = RegWrite    && (write_reg != '0);
    assign iss_en = issue_valid && (issue_reg != '0);

    // Set has priority over clear so a new producer overtakes an older one.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_entry
                assign busy_next[gi] = (iss_en && (issue_reg == AW'(gi))) ||
                                       (busy_reg[gi] && !(wr_en && (write_reg == AW'(gi))));
            end
        end
    endgenerate

    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_count_next = busy_count_next + (AW+1)'(busy_next[i]);
        end
    end

    // Entry 0 is cleared by reset and never written, so it reads as zero.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy_reg       <= '0;
            busy_count_reg <= '0;
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            busy_reg       <= busy_next;
            busy_count_reg <= busy_count_next;
            if (wr_en) begin
                mem_reg[write_reg] <= write_data;
            end
        end
    end

    assign busy_count = busy_count_reg;

    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];

    assign rd_addr[0] = rd_reg1;
    assign rd_addr[1] = rd_reg2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic hit;
            always_comb begin
                hit         = (BYPASS != 0) && wr_en && (write_reg == rd_addr[gi]);
                rd_data[gi] = hit ? write_data : mem_reg[rd_addr[gi]];
                rd_busy[gi] = hit ? 1'b0 : busy_reg[rd_addr[gi]];
            end
        end
    endgenerate

    assign rd_data1 = rd_data[0];
    assign rd_data2 = rd_data[1];
    assign rd_busy1 = rd_busy[0];
    assign rd_busy2 = rd_busy[1];

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench: a forwarding and a non-forwarding register file share one
// stimulus stream; expected values are hand-computed constants.
module tb_rf_scoreboard;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            nrst;
    logic [AW-1:0]   rd_reg1, rd_reg2, write_reg, issue_reg;
    logic            reg_write, issue_valid;
    logic [XLEN-1:0] write_data;

    logic [XLEN-1:0] rd_data1, rd_data2, rd_data1_nb, rd_data2_nb;
    logic            rd_busy1, rd_busy2, rd_busy1_nb, rd_busy2_nb;
    logic [AW:0]     busy_count, busy_count_nb;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    rf_scoreboard #(.XLEN(XLEN), .NREG(32), .AW(AW), .BYPASS(1)) dut_byp (
        .clk(clk), .nrst(nrst),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .RegWrite(reg_write), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .busy_count(busy_count)
    );

    rf_scoreboard #(.XLEN(XLEN), .NREG(32), .AW(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .nrst(nrst),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_data1(rd_data1_nb), .rd_data2(rd_data2_nb),
        .rd_busy1(rd_busy1_nb), .rd_busy2(rd_busy2_nb),
        .RegWrite(reg_write), .write_reg(write_reg), .write_data(write_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .busy_count(busy_count_nb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle();
        reg_write   = 1'b0;
        write_reg   = '0;
        write_data  = '0;
        issue_valid = 1'b0;
        issue_reg   = '0;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later or mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        rd_reg1 = '0;
        rd_reg2 = '0;
        idle();
        step();
        nrst = 1'b1;

        // Preload r5, then reset with a pending issue that must be ignored
        reg_write = 1'b1; write_reg = 5; write_data = 64'hA5;
        step();
        idle();
        rd_reg1 = 5;
        #2 check("preload_r5", rd_data1, 64'hA5);
        step();
        nrst = 1'b0;
        issue_valid = 1'b1; issue_reg = 5;
        step();
        nrst = 1'b1;
        idle();
        #2;
        check("rst_data1", rd_data1, 64'h0);
        check("rst_busy1", rd_busy1, 1'b0);
        check("rst_count", busy_count, 0);

        // Write r7 while reading it: forwarded vs. next-cycle visibility
        rd_reg1 = 7;
        reg_write = 1'b1; write_reg = 7; write_data = 64'h1234;
        #2;
        check("byp_wr_data", rd_data1, 64'h1234);
        check("nb_wr_old", rd_data1_nb, 64'h0);
        step();
        idle();
        #2;
        check("nb_wr_new", rd_data1_nb, 64'h1234);
        check("nb_wr_busy", rd_busy1_nb, 1'b0);

        // Register 0 ignores write and issue
        rd_reg1 = 0; rd_reg2 = 0;
        reg_write = 1'b1; write_reg = 0; write_data = 64'hFFFF;
        issue_valid = 1'b1; issue_reg = 0;
        #2;
        check("x0_data_same", rd_data1, 64'h0);
        check("x0_busy_same", rd_busy2, 1'b0);
        step();
        idle();
        #2;
        check("x0_data_next", rd_data2, 64'h0);
        check("x0_busy_next", rd_busy1, 1'b0);
        check("x0_count", busy_count, 0);

        // Scoreboard set and release on r3
        rd_reg1 = 3;
        issue_valid = 1'b1; issue_reg = 3;
        #2 check("iss_same_busy", rd_busy1, 1'b0);
        step();
        idle();
        #2;
        check("iss_busy", rd_busy1, 1'b1);
        check("iss_count", busy_count, 1);
        reg_write = 1'b1; write_reg = 3; write_data = 64'h55;
        #2;
        check("wb_byp_busy", rd_busy1, 1'b0);
        check("wb_byp_data", rd_data1, 64'h55);
        check("wb_nb_busy", rd_busy1_nb, 1'b1);
        check("wb_nb_data", rd_data1_nb, 64'h0);
        step();
        idle();
        #2;
        check("wb_count", busy_count, 0);
        check("wb_nb_count", busy_count_nb, 0);
        check("wb_nb_after", rd_data1_nb, 64'h55);

        // Collision on r9: issue and writeback together, set wins
        issue_valid = 1'b1; issue_reg = 9;
        step();
        rd_reg1 = 9; rd_reg2 = 9;
        reg_write = 1'b1; write_reg = 9; write_data = 64'h77;
        #2;
        check("col_byp_busy", rd_busy2, 1'b0);
        check("col_byp_data", rd_data2, 64'h77);
        step();
        idle();
        #2;
        check("col_busy", rd_busy2, 1'b1);
        check("col_data", rd_data2, 64'h77);
        check("col_port1_eq", rd_data1, 64'h77);
        check("col_count", busy_count, 1);
        check("col_nb_busy", rd_busy1_nb, 1'b1);

        // Re-issue to a busy register keeps count at 1; then release r9
        issue_valid = 1'b1; issue_reg = 9;
        step();
        idle();
        #2 check("reiss_count", busy_count, 1);
        reg_write = 1'b1; write_reg = 9; write_data = 64'h78;
        step();
        idle();
        #2 check("rel9_count", busy_count, 0);

        // Fill r1..r31; count tracks each edge and saturates at 31
        for (int r = 1; r < 32; r++) begin
            issue_valid = 1'b1; issue_reg = AW'(r);
            step();
            if (r == 1 || r == 16 || r == 31) begin
                #2 check($sformatf("fill_count_r%0d", r), busy_count, (AW+1)'(r));
            end
        end
        idle();
        rd_reg1 = 31;
        #2;
        check("fill_busy31", rd_busy1, 1'b1);
        check("fill_nb_count", busy_count_nb, 31);

        // Mid-sequence reset: everything clears the next cycle
        nrst = 1'b0;
        issue_valid = 1'b1; issue_reg = 12;
        reg_write = 1'b1; write_reg = 8; write_data = 64'hDEAD;
        step();
        nrst = 1'b1;
        idle();
        rd_reg1 = 12; rd_reg2 = 7;
        #2;
        check("mrst_count", busy_count, 0);
        check("mrst_busy12", rd_busy1, 1'b0);
        check("mrst_data7", rd_data2, 64'h0);
        rd_reg1 = 8;
        #1 check("mrst_data8", rd_data1, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised integer register file with a built-in per-register busy scoreboard and write-to-read bypass. It is the next-generation register file for the pipelined core: the decode stage reads two operands plus their busy status, and marks the destination register busy when it issues an instruction. Writeback writes the result and clears the busy bit. Register 0 is hardwired to zero and never busy.

## Interface
- XLEN, 64, data width of every register
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, 5, register address width; must equal log2(NREG)
- BYPASS, 1, 1 = same-cycle writeback forwarded to the read ports; 0 = no forwarding

- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  synchronous, active-low reset
- rd_reg1  in  AW  read port 1 address
- rd_reg2  in  AW  read port 2 address
- rd_data1  out  XLEN  read port 1 data (combinational)
- rd_data2  out  XLEN  read port 2 data (combinational)
- rd_busy1  out  1  register at rd_reg1 has a pending write
- rd_busy2  out  1  register at rd_reg2 has a pending write
- RegWrite  in  1  writeback strobe
- write_reg  in  AW  writeback destination
- write_data  in  XLEN  writeback data
- issue_valid  in  1  decode issues an instruction that writes issue_reg
- issue_reg  in  AW  destination being marked busy
- busy_count  out  AW+1  number of registers currently busy (registered)

## Operation
- Storage: NREG×XLEN data array plus NREG busy bits. Entry 0 always reads 0 and is never busy. Writes and issues to register 0 are ignored.
- Reset: while nrst=0 at a rising edge, all data entries, all busy bits, and busy_count clear to 0. RegWrite and issue_valid are ignored during that cycle.
- Write: when RegWrite=1 and write_reg≠0, the entry is updated with write_data at the edge, and busy[write_reg] clears.
- Issue: when issue_valid=1 and issue_reg≠0, busy[issue_reg] sets at the edge.
- Same-cycle issue and writeback to the same register: set wins, so the busy bit stays 1. This models a new producer overtaking the old one. The data is still written.
- Issue to a register that is already busy: the bit stays 1. There is no counting per register.
- Writeback to a register that is not busy: data is written and the bit stays 0. This is not an error.
- Read port n, with BYPASS=1:
  - If RegWrite=1, write_reg=rd_regn, and rd_regn≠0, then rd_datan = write_data and rd_busyn = 0.
  - Otherwise rd_datan = array[rd_regn] and rd_busyn = busy[rd_regn].
- Read port n, with BYPASS=0: always array[rd_regn] and busy[rd_regn]. The written value appears on the cycle after the edge.
- Same-cycle issue does not affect rd_busyn. The busy bit is visible the cycle after issue.
- rd_reg1 = rd_reg2 is legal; both ports return identical values.
- busy_count: the population count of the busy bits after each edge, computed from next-state bits. Range 0..NREG-1, with no wrap.

## Timing
- Read latency: 0 cycles (combinational from address, or from the bypass inputs).
- Write latency: data is visible in the array 1 cycle after the strobe edge.
- Issue latency: busy is visible 1 cycle after issue.
- Writeback release: busy bit clears 1 cycle after writeback. With BYPASS=1, the read port already shows it cleared in the writeback cycle.
- busy_count: updated at every edge, reflecting the state after that edge. Reset value 0.
- All outputs after reset (any addresses): rd_data = 0, rd_busy = 0.

## Test plan
- Reset: preload r5=0xA5, assert nrst=0 for one edge, read r5 → rd_data1=0, rd_busy1=0, busy_count=0.
- Write/read with BYPASS=1: RegWrite r7=0x1234 and rd_reg1=7 in the same cycle → rd_data1=0x1234 that cycle. With BYPASS=0 → old value that cycle, 0x1234 the next cycle.
- x0: RegWrite r0=0xFFFF plus issue r0 → rd_data=0, rd_busy=0, busy_count unchanged.
- Scoreboard: issue r3 → next cycle rd_busy=1 and busy_count=1. Writeback r3=0x55 → same cycle (BYPASS=1) rd_busy=0 and data 0x55; next cycle busy_count=0.
- Collision: r9 busy, issue r9 and writeback r9=0x77 in the same cycle → next cycle busy=1, data=0x77, busy_count=1.
- Fill: issue r1..r31 on consecutive cycles → busy_count reaches 31. Assert reset mid-sequence → all cleared next cycle.
